fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DEPTH, default 4, queue entries, power of two, 2..16.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect  input  1  flush queue and restart fetch at redirect_pc (branch/jump from decode/control).
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] forced to 0.
REQ-007 imem_req_valid  output  1  instruction-memory read request valid.
REQ-008 imem_req_ready  input  1  memory accepts request this cycle.
REQ-009 imem_req_addr  output  32  byte address of requested word.
REQ-010 imem_resp_valid  input  1  read data returned; in request order, latency >= 1 cycle.
REQ-011 imem_resp_data  input  32  returned instruction word.
REQ-012 inst_valid  output  1  queue head holds an instruction for decode.
REQ-013 inst_ready  input  1  decode consumes head this cycle.
REQ-014 inst  output  32  head instruction word.
REQ-015 inst_pc  output  32  address of head instruction.

Function
REQ-016 Request handshake: fires when imem_req_valid & imem_req_ready; fetch_pc then advances by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 imem_req_valid SHALL be high only when state == RUN, redirect low, and occupancy + outstanding < DEPTH (credit rule; queue never overflows).
REQ-018 imem_req_valid/imem_req_addr SHALL hold stable until accepted, unless redirect asserts.
REQ-019 outstanding counter: +1 on request fire, -1 on response; simultaneous fire and response leaves it unchanged.
REQ-020 Non-stale response SHALL be enqueued with its PC (PC captured at request fire, kept in a PC FIFO of DEPTH entries).
REQ-021 Queue is registered: earliest inst_valid is the cycle after imem_resp_valid; no combinational response-to-inst path.
REQ-022 Dequeue on inst_valid & inst_ready; enqueue and dequeue in the same cycle with queue full or empty SHALL both succeed as applicable (occupancy unchanged).
REQ-023 FSM states: RUN, FLUSH.
REQ-024 RUN -> FLUSH on redirect when outstanding after this cycle (including any request firing this cycle, minus any response this cycle) > 0; otherwise stays RUN.
REQ-025 On redirect (any state): queue emptied, fetch_pc <= {redirect_pc[31:2],2'b00}, stale counter <= outstanding after this cycle; the response arriving in the redirect cycle SHALL be dropped.
REQ-026 FLUSH: no requests issued; each response decrements stale counter and is dropped; FLUSH -> RUN when stale counter reaches 0 this cycle.
REQ-027 A dequeue handshake coinciding with redirect is void; decode ignores that instruction.
REQ-028 Redirect during FLUSH SHALL reload fetch_pc; stale counter continues to cover all outstanding.
REQ-029 inst_valid SHALL be 0 whenever the queue is empty; inst/inst_pc don't-care then.

Reset
REQ-030 On rst: fetch_pc = RESET_PC, state = RUN, occupancy = 0, outstanding = 0, stale = 0.
REQ-031 During rst: imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0; first request the cycle after rst deasserts.
REQ-032 Reset mid-operation abandons in-flight requests; memory side is reset concurrently by the same rst.

Structure
REQ-033 Shared package: instruction width 32, address width 32, PC step 4, FSM state enum {RUN, FLUSH}.
REQ-034 One sub-module: fetch_fifo (parameterised sync FIFO, data = {pc,inst}, flush input, full/empty/count), instantiated once.

Verification
REQ-035 Reset, memory 1-cycle latency, inst_ready=1: requests at 0,4,8...; inst_pc 0 with inst_valid on cycle 2 after reset release, one instruction per cycle thereafter.
REQ-036 inst_ready=0, DEPTH=4: exactly 4 requests issued (0x0..0xC), then imem_req_valid=0; raising inst_ready delivers 0x0..0xC in order, fetch resumes at 0x10.
REQ-037 Memory latency 3, two requests in flight, redirect to 0x0000_0101: both stale responses dropped, state FLUSH 3 cycles max, next request address 0x0000_0100, first inst_pc 0x100.
REQ-038 imem_req_ready low 5 cycles: imem_req_addr holds 0x8 throughout; no duplicate or skipped PC.
REQ-039 Redirect in the same cycle as a response and an inst handshake: response dropped, queue empty next cycle, fetch restarts at redirect_pc.
REQ-040 RESET_PC=32'hFFFF_FFF8: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 delivered in order.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_STEP = 4;

    // RUN issues requests; FLUSH drains responses made stale by a redirect
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // One instruction-queue entry: the fetched word tagged with its address
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = ADDR_W + INST_W;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; simultaneous push/pop succeeds even when full.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    // a full queue still accepts a push when the head leaves in the same cycle
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // pointers and occupancy; flush discards everything
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// queue, and redirect handling that drops responses to abandoned requests.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [ADDR_W-1:0] o_imem_req_addr,
    input  logic              i_imem_resp_valid,
    input  logic [INST_W-1:0] i_imem_resp_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_stale;
    logic [PTR_W-1:0]  r_pcq_wr;
    logic [PTR_W-1:0]  r_pcq_rd;
    logic [ADDR_W-1:0] r_pcq [DEPTH];

    logic               w_fire;
    logic               w_resp;
    logic               w_credit;
    logic               w_enq;
    logic               w_deq;
    logic               w_full;
    logic               w_empty;
    logic               w_show;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [SUM_W-1:0]   w_occ_sum;
    fetch_entry_t       w_enq_entry;
    fetch_entry_t       w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    // a response with nothing in flight is ignored so counters never underflow
    assign w_resp    = i_imem_resp_valid && (r_outstanding != '0);
    // queued plus in-flight never exceeds DEPTH, so the queue cannot overflow
    assign w_occ_sum = SUM_W'(w_count) + SUM_W'(r_outstanding);
    assign w_credit  = !w_full && (w_occ_sum < SUM_W'(DEPTH));

    assign o_imem_req_valid = !rst && (r_state == RUN) && !i_redirect && w_credit;
    assign o_imem_req_addr  = r_fetch_pc;
    assign w_fire           = o_imem_req_valid && i_imem_req_ready;

    assign w_outstanding_nxt = r_outstanding + CNT_W'(w_fire) - CNT_W'(w_resp);

    // only live responses enter the queue; a redirect voids both queue ports
    assign w_enq            = w_resp && (r_state == RUN) && !i_redirect;
    assign w_deq            = i_inst_ready && !i_redirect;
    assign w_enq_entry.pc   = r_pcq[r_pcq_rd];
    assign w_enq_entry.inst = i_imem_resp_data;

    assign w_head       = fetch_entry_t'(w_head_bits);
    assign w_show       = !rst && !w_empty;
    assign o_inst_valid = w_show;
    assign o_inst       = w_show ? w_head.inst : '0;
    assign o_inst_pc    = w_show ? w_head.pc   : '0;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_redirect),
        .i_push  (w_enq),
        .i_data  (w_enq_entry),
        .i_pop   (w_deq),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // PC FIFO: remembers the address of each accepted request until it returns
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
    end

    // fetch pc, in-flight bookkeeping and the RUN/FLUSH state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_fire) begin
                r_pcq_wr <= r_pcq_wr + PTR_W'(1);
            end
            if (w_resp) begin
                r_pcq_rd <= r_pcq_rd + PTR_W'(1);
            end
            if (i_redirect) begin
                // everything still in flight after this edge is now stale
                r_fetch_pc <= i_redirect_pc & ~ADDR_W'(3);
                r_stale    <= w_outstanding_nxt;
                r_state    <= (w_outstanding_nxt != '0) ? FLUSH : RUN;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
                end
                case (r_state)
                    FLUSH: begin
                        if (w_resp) begin
                            r_stale <= r_stale - CNT_W'(1);
                        end
                        if ((r_stale == '0) || (w_resp && (r_stale == CNT_W'(1)))) begin
                            r_state <= RUN;
                        end
                    end
                    default: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        req_valid2, resp_valid2, inst_valid2;
    logic [31:0] req_addr2, resp_data2, inst2, inst_pc2;

    int          lat = 1;
    logic        mem_ready = 1'b1;
    int          cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [31:0] deq_log[$];
    logic [31:0] deq_log2[$];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_redirect        (redirect),
        .i_redirect_pc     (redirect_pc),
        .o_imem_req_valid  (req_valid),
        .i_imem_req_ready  (req_ready),
        .o_imem_req_addr   (req_addr),
        .i_imem_resp_valid (resp_valid),
        .i_imem_resp_data  (resp_data),
        .o_inst_valid      (inst_valid),
        .i_inst_ready      (inst_ready),
        .o_inst            (inst),
        .o_inst_pc         (inst_pc)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk               (clk),
        .rst               (rst),
        .i_redirect        (1'b0),
        .i_redirect_pc     (32'h0),
        .o_imem_req_valid  (req_valid2),
        .i_imem_req_ready  (1'b1),
        .o_imem_req_addr   (req_addr2),
        .i_imem_resp_valid (resp_valid2),
        .i_imem_resp_data  (resp_data2),
        .o_inst_valid      (inst_valid2),
        .i_inst_ready      (1'b1),
        .o_inst            (inst2),
        .o_inst_pc         (inst_pc2)
    );

    assign req_ready = mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_DEAD;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // memory for dut: in-order responses, fixed latency of lat cycles
    always @(posedge clk) begin
        resp_valid <= 1'b0;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (req_valid && mem_ready) begin
                pend_addr.push_back(req_addr);
                pend_due.push_back(cyc + lat - 1);
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                resp_valid <= 1'b1;
                resp_data  <= memf(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    // memory for dut2: always ready, one-cycle latency
    always @(posedge clk) begin
        resp_valid2 <= req_valid2 && !rst;
        resp_data2  <= memf(req_addr2);
    end

    // record accepted requests and delivered instructions
    always @(posedge clk) begin
        if (!rst) begin
            if (req_valid && mem_ready) req_log.push_back(req_addr);
            if (inst_valid && inst_ready && !redirect) deq_log.push_back(inst_pc);
            if (inst_valid2) deq_log2.push_back(inst_pc2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        req_log.delete();
        deq_log.delete();
        rst = 1'b0;
    endtask

    task automatic wait_inst(input string tag);
        int w;
        w = 0;
        while (!inst_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(w < 20), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_req_valid2", 32'(req_valid2), 32'd0);

        // 1-cycle memory, decode always ready: one instruction per cycle
        req_log.delete();
        deq_log.delete();
        rst = 1'b0;
        #1;
        chk("r035_first_req_valid", 32'(req_valid), 32'd1);
        chk("r035_first_req_addr", req_addr, 32'h0);
        @(negedge clk);
        chk("r035_c1_inst_valid", 32'(inst_valid), 32'd0);
        chk("r035_c1_req_addr", req_addr, 32'h4);
        @(negedge clk);
        chk("r035_c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("r035_c2_inst_pc", inst_pc, 32'h0);
        chk("r035_c2_inst", inst, memf(32'h0));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("r035_stream_valid", 32'(inst_valid), 32'd1);
            chk("r035_stream_pc", inst_pc, 32'(4 * i));
        end

        // decode stalled: credit limits issue to DEPTH requests
        inst_ready = 1'b0;
        lat = 1;
        do_reset();
        repeat (10) @(negedge clk);
        chk("r036_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("r036_req_addr", qget(req_log, i), 32'(4 * i));
        chk("r036_req_valid_stalled", 32'(req_valid), 32'd0);
        chk("r036_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("r036_deq_pc", qget(deq_log, i), 32'(4 * i));
        chk("r036_resume_addr", qget(req_log, 4), 32'h10);

        // 3-cycle memory, redirect with two requests in flight
        lat = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("r037_inflight", 32'(req_log.size()), 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0101;
        #1;
        chk("r037_redirect_blocks_req", 32'(req_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("r037_flush_c1_req_valid", 32'(req_valid), 32'd0);
        chk("r037_flush_c1_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("r037_flush_c2_req_valid", 32'(req_valid), 32'd0);
        chk("r037_flush_c2_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("r037_run_req_valid", 32'(req_valid), 32'd1);
        chk("r037_run_req_addr", req_addr, 32'h100);
        wait_inst("r037_wait_inst");
        chk("r037_first_inst_pc", inst_pc, 32'h100);
        chk("r037_first_inst", inst, memf(32'h100));
        chk("r037_next_req", qget(req_log, 2), 32'h100);

        // memory back-pressure: request must hold
        lat = 1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("r038_hold_valid", 32'(req_valid), 32'd1);
            chk("r038_hold_addr", req_addr, 32'h8);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) chk("r038_req_seq", qget(req_log, i), 32'(4 * i));
        for (int i = 0; i < 5; i++) chk("r038_deq_seq", qget(deq_log, i), 32'(4 * i));

        // redirect coinciding with a response and a dequeue
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("r039_pre_inst_valid", 32'(inst_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("r039_queue_empty", 32'(inst_valid), 32'd0);
        chk("r039_req_valid", 32'(req_valid), 32'd1);
        chk("r039_req_addr", req_addr, 32'h200);
        wait_inst("r039_wait_inst");
        chk("r039_inst_pc", inst_pc, 32'h200);
        @(negedge clk);
        chk("r039_first_deq", qget(deq_log, 0), 32'h200);

        // address wrap from a high reset pc (second instance)
        chk("r040_deq0", qget(deq_log2, 0), 32'hFFFF_FFF8);
        chk("r040_deq1", qget(deq_log2, 1), 32'hFFFF_FFFC);
        chk("r040_deq2", qget(deq_log2, 2), 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
